// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game: FSM state codes and ROM contents.
package jogo_pkg;

  // Encodings are visible on db_estado, so each state has a fixed code.
  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPrepara    = 4'h1,
    StEspera     = 4'h2,
    StRegistra   = 4'h4,
    StCompara    = 4'h5,
    StProxJogada = 4'h6,
    StProxRodada = 4'h7,
    StFimAcerto  = 4'hA,
    StFimTimeout = 4'hD,
    StFimErro    = 4'hE
  } estado_e;

  // Entry idx lights switch (idx mod n_chaves); callers truncate to N_CHAVES bits.
  function automatic logic [31:0] rom_valor(int unsigned idx, int unsigned n_chaves);
    return 32'd1 << (idx % n_chaves);
  endfunction

endpackage

// File: rtl/sync_rom_jogo.sv
// Synchronous-read ROM holding the expected play for each sequence position.
module sync_rom_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned N_CHAVES  = 4,
  parameter int unsigned N_JOGADAS = 16,
  localparam int unsigned A        = $clog2(N_JOGADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [A-1:0]        endereco_i,
  output logic [N_CHAVES-1:0] dado_o
);

  logic [N_CHAVES-1:0] tabela [N_JOGADAS];
  logic [N_CHAVES-1:0] dado_q;

  // Constant table contents, folded away by synthesis.
  always_comb begin
    for (int unsigned i = 0; i < N_JOGADAS; i++) begin
      tabela[i] = N_CHAVES'(rom_valor(i, N_CHAVES));
    end
  end

  // One-cycle read latency; output is zero while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_q <= '0;
    end else begin
      dado_q <= tabela[endereco_i];
    end
  end

  assign dado_o = dado_q;

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: rounds of growing ROM prefixes, edge-detected plays,
// optional per-play timeout, Moore status outputs.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int unsigned N_CHAVES       = 4,
  parameter int unsigned N_JOGADAS      = 16,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  localparam int unsigned A             = $clog2(N_JOGADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [N_CHAVES-1:0] leds,
  output logic [A-1:0]        db_rodada,
  output logic [A-1:0]        db_contagem,
  output logic [N_CHAVES-1:0] db_memoria,
  output logic [N_CHAVES-1:0] db_jogada,
  output logic [3:0]          db_estado,
  output logic                db_tem_jogada
);

  // A disabled timeout still gets a 1-bit timer so no zero-width vector appears.
  localparam bit             TimeoutAtivo = (TIMEOUT_CICLOS != 0);
  localparam int unsigned    TW           = TimeoutAtivo ? $clog2(TIMEOUT_CICLOS + 1) : 1;
  localparam logic [TW-1:0]  TimerLimite  = TW'(TimeoutAtivo ? TIMEOUT_CICLOS - 1 : 0);
  localparam logic [A-1:0]   UltimaRodada = A'(N_JOGADAS - 1);

  estado_e             estado_q, estado_d;
  logic [A-1:0]        rodada_q, rodada_d;
  logic [A-1:0]        contagem_q, contagem_d;
  logic [N_CHAVES-1:0] jogada_q, jogada_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_CHAVES-1:0] chaves_prev_q;
  logic [N_CHAVES-1:0] rom_dado;
  logic                tem_jogada;

  sync_rom_jogo #(
    .N_CHAVES  (N_CHAVES),
    .N_JOGADAS (N_JOGADAS)
  ) u_rom (
    .clock      (clock),
    .reset      (reset),
    .endereco_i (contagem_q),
    .dado_o     (rom_dado)
  );

  // A play is the first cycle the switches leave all-zero; holding them gives one play.
  assign tem_jogada = (chaves != '0) && (chaves_prev_q == '0);

  // Previous-switch register for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chaves_prev_q <= '0;
    end else begin
      chaves_prev_q <= chaves;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= StInicial;
      rodada_q   <= '0;
      contagem_q <= '0;
      jogada_q   <= '0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      rodada_q   <= rodada_d;
      contagem_q <= contagem_d;
      jogada_q   <= jogada_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state and datapath updates; final states freeze counters for debug.
  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    contagem_d = contagem_q;
    jogada_d   = jogada_q;
    timer_d    = timer_q;
    unique case (estado_q)
      StInicial: begin
        if (iniciar) estado_d = StPrepara;
      end
      StPrepara: begin
        rodada_d   = '0;
        contagem_d = '0;
        jogada_d   = '0;
        timer_d    = '0;
        estado_d   = StEspera;
      end
      StEspera: begin
        // A play on the last allowed cycle still wins over the timeout.
        if (tem_jogada) begin
          estado_d = StRegistra;
        end else if (TimeoutAtivo && (timer_q == TimerLimite)) begin
          estado_d = StFimTimeout;
        end else if (TimeoutAtivo) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRegistra: begin
        jogada_d = chaves;
        estado_d = StCompara;
      end
      StCompara: begin
        if (jogada_q != rom_dado) begin
          estado_d = StFimErro;
        end else if ((contagem_q == rodada_q) && (rodada_q == UltimaRodada)) begin
          estado_d = StFimAcerto;
        end else if (contagem_q == rodada_q) begin
          estado_d = StProxRodada;
        end else begin
          estado_d = StProxJogada;
        end
      end
      StProxJogada: begin
        contagem_d = contagem_q + 1'b1;
        timer_d    = '0;
        estado_d   = StEspera;
      end
      StProxRodada: begin
        rodada_d   = rodada_q + 1'b1;
        contagem_d = '0;
        timer_d    = '0;
        estado_d   = StEspera;
      end
      StFimAcerto, StFimErro, StFimTimeout: begin
        if (iniciar) estado_d = StPrepara;
      end
      default: estado_d = StInicial;
    endcase
  end

  // Moore outputs decoded from the state register.
  assign acertou       = (estado_q == StFimAcerto);
  assign errou         = (estado_q == StFimErro);
  assign timeout       = (estado_q == StFimTimeout);
  assign pronto        = acertou | errou | timeout;
  assign leds          = rom_dado;
  assign db_memoria    = rom_dado;
  assign db_rodada     = rodada_q;
  assign db_contagem   = contagem_q;
  assign db_jogada     = jogada_q;
  assign db_estado     = estado_q;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: scenario tasks with a queue of expected final snapshots.
module tb_jogo_sequencia_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, iniciar2;
  logic [3:0] chaves, chaves2;

  logic       acertou, errou, timeout, pronto, db_tem_jogada;
  logic [3:0] leds, db_memoria, db_jogada, db_estado;
  logic [1:0] db_rodada, db_contagem;

  logic       acertou2, errou2, timeout2, pronto2, db_tem_jogada2;
  logic [3:0] leds2, db_memoria2, db_jogada2, db_estado2;
  logic [1:0] db_rodada2, db_contagem2;

  typedef struct packed {
    logic [3:0] estado;
    logic [1:0] rodada;
    logic [1:0] contagem;
    logic [3:0] jogada;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       pronto;
  } snap_t;

  snap_t sb[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clock = ~clock;

  jogo_sequencia_param #(
    .N_CHAVES       (4),
    .N_JOGADAS      (4),
    .TIMEOUT_CICLOS (20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .chaves        (chaves),
    .acertou       (acertou),
    .errou         (errou),
    .timeout       (timeout),
    .pronto        (pronto),
    .leds          (leds),
    .db_rodada     (db_rodada),
    .db_contagem   (db_contagem),
    .db_memoria    (db_memoria),
    .db_jogada     (db_jogada),
    .db_estado     (db_estado),
    .db_tem_jogada (db_tem_jogada)
  );

  jogo_sequencia_param #(
    .N_CHAVES       (4),
    .N_JOGADAS      (4),
    .TIMEOUT_CICLOS (0)
  ) dut_sem_timeout (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar2),
    .chaves        (chaves2),
    .acertou       (acertou2),
    .errou         (errou2),
    .timeout       (timeout2),
    .pronto        (pronto2),
    .leds          (leds2),
    .db_rodada     (db_rodada2),
    .db_contagem   (db_contagem2),
    .db_memoria    (db_memoria2),
    .db_jogada     (db_jogada2),
    .db_estado     (db_estado2),
    .db_tem_jogada (db_tem_jogada2)
  );

  function automatic snap_t sample();
    return {db_estado, db_rodada, db_contagem, db_jogada, acertou, errou, timeout, pronto};
  endfunction

  function automatic snap_t mk(logic [3:0] e, logic [1:0] r, logic [1:0] c, logic [3:0] j,
                               logic a, logic er, logic t, logic p);
    return {e, r, c, j, a, er, t, p};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("estado=%h rodada=%0d contagem=%0d jogada=%h acertou=%b errou=%b timeout=%b pronto=%b",
                     s.estado, s.rodada, s.contagem, s.jogada, s.acertou, s.errou, s.timeout,
                     s.pronto);
  endfunction

  // All tasks below start and end at a falling edge.
  task automatic start_game();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  task automatic play(input logic [3:0] v);
    chaves = v;
    repeat (3) @(negedge clock);
    chaves = 4'h0;
    repeat (3) @(negedge clock);
  endtask

  // Waits (bounded) for a final state and returns the snapshot there.
  task automatic wait_final(input string name, output snap_t obs, output bit ok);
    int n = 0;
    while (!pronto && n < 300) begin
      @(negedge clock);
      n++;
    end
    ok  = pronto;
    obs = sample();
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: no final state within 300 cycles, now %s", name, fmt(obs));
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    iniciar  = 1'b0;
    iniciar2 = 1'b0;
    chaves   = 4'h0;
    chaves2  = 4'h0;
    repeat (3) @(negedge clock);
    tests++;
    if ({sample(), leds} !== {mk(4'h0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 0), 4'h0}) begin
      fails++;
      $display("FAIL reset_state: got %s leds=%h, want all zero", fmt(sample()), leds);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (leds !== 4'h1) begin
      fails++;
      $display("FAIL reset_leds: got %h want 1", leds);
    end
    tests++;
    if (db_memoria !== 4'h1 || db_estado !== 4'h0) begin
      fails++;
      $display("FAIL reset_memoria: got mem=%h estado=%h want 1/0", db_memoria, db_estado);
    end
  endtask

  task automatic test_full_win();
    snap_t obs, exp;
    bit    ok;
    start_game();
    sb.push_back(mk(4'hA, 2'd3, 2'd3, 4'h8, 1, 0, 0, 1));
    play(4'h1);
    play(4'h1); play(4'h2);
    play(4'h1); play(4'h2); play(4'h4);
    play(4'h1); play(4'h2); play(4'h4); play(4'h8);
    wait_final("full_win", obs, ok);
    exp = sb.pop_front();
    if (ok) begin
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL full_win: got %s want %s", fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_error();
    snap_t obs, exp;
    bit    ok;
    start_game();
    sb.push_back(mk(4'hE, 2'd2, 2'd1, 4'h8, 0, 1, 0, 1));
    play(4'h1);
    play(4'h1); play(4'h2);
    play(4'h1); play(4'h8);
    wait_final("error", obs, ok);
    exp = sb.pop_front();
    if (ok) begin
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL error: got %s want %s", fmt(obs), fmt(exp));
      end
    end
  endtask

  // Restart from FIM_ERRO, then leave the new game idle until it times out.
  task automatic test_restart_and_timeout();
    snap_t obs, exp;
    bit    ok;
    int    n;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    tests++;
    if (db_estado !== 4'h1 || {acertou, errou, timeout, pronto} !== 4'b0000) begin
      fails++;
      $display("FAIL restart_prepara: got estado=%h flags=%b want 1/0000",
               db_estado, {acertou, errou, timeout, pronto});
    end
    @(negedge clock);
    tests++;
    if (db_estado !== 4'h2 || db_rodada !== 2'd0 || db_contagem !== 2'd0 || db_jogada !== 4'h0) begin
      fails++;
      $display("FAIL restart_espera: got %s want estado=2 with counters cleared", fmt(sample()));
    end
    sb.push_back(mk(4'hD, 2'd0, 2'd0, 4'h0, 0, 0, 1, 1));
    n = 0;
    while (!pronto && n < 100) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n != 20) begin
      fails++;
      $display("FAIL timeout_cycles: got %0d cycles want 20", n);
    end
    wait_final("timeout", obs, ok);
    exp = sb.pop_front();
    if (ok) begin
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL timeout: got %s want %s", fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_held_switch();
    snap_t obs, exp;
    bit    ok;
    int    registra = 0;
    start_game();
    play(4'h1);
    sb.push_back(mk(4'hD, 2'd1, 2'd1, 4'h1, 0, 0, 1, 1));
    chaves = 4'h1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (db_estado == 4'h4) registra++;
    end
    chaves = 4'h0;
    tests++;
    if (registra != 1) begin
      fails++;
      $display("FAIL held_single_play: got %0d plays want 1", registra);
    end
    wait_final("held_timeout", obs, ok);
    exp = sb.pop_front();
    if (ok) begin
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL held_timeout: got %s want %s", fmt(obs), fmt(exp));
      end
    end
  endtask

  // Switch edge lands exactly on the cycle where the timer hits its limit.
  task automatic test_play_on_timeout_cycle();
    snap_t obs, exp;
    bit    ok;
    start_game();
    repeat (19) @(negedge clock);
    play(4'h1);
    tests++;
    if (db_estado !== 4'h2 || db_rodada !== 2'd1 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL edge_on_timeout: got %s want estado=2 rodada=1 timeout=0", fmt(sample()));
    end
    sb.push_back(mk(4'hD, 2'd1, 2'd0, 4'h1, 0, 0, 1, 1));
    wait_final("edge_then_timeout", obs, ok);
    exp = sb.pop_front();
    if (ok) begin
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL edge_then_timeout: got %s want %s", fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid_game();
    start_game();
    play(4'h1);
    play(4'h1); play(4'h2);
    tests++;
    if (db_rodada !== 2'd2 || db_estado !== 4'h2) begin
      fails++;
      $display("FAIL mid_round2: got rodada=%0d estado=%h want 2/2", db_rodada, db_estado);
    end
    chaves = 4'h1;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (sample() !== mk(4'h0, 2'd0, 2'd0, 4'h0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL async_reset: got %s want all zero", fmt(sample()));
    end
    tests++;
    if (leds !== 4'h0) begin
      fails++;
      $display("FAIL async_reset_leds: got %h want 0", leds);
    end
    @(negedge clock);
    reset  = 1'b0;
    chaves = 4'h0;
    @(negedge clock);
  endtask

  task automatic test_timeout_disabled();
    iniciar2 = 1'b1;
    @(negedge clock);
    iniciar2 = 1'b0;
    repeat (1000) @(negedge clock);
    tests++;
    if (db_estado2 !== 4'h2 || timeout2 !== 1'b0 || pronto2 !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout_idle: got estado=%h timeout=%b pronto=%b want 2/0/0",
               db_estado2, timeout2, pronto2);
    end
    chaves2 = 4'h1;
    repeat (3) @(negedge clock);
    chaves2 = 4'h0;
    repeat (3) @(negedge clock);
    tests++;
    if (db_estado2 !== 4'h2 || db_rodada2 !== 2'd1) begin
      fails++;
      $display("FAIL no_timeout_play: got estado=%h rodada=%0d want 2/1", db_estado2, db_rodada2);
    end
  endtask

  initial begin
    test_reset();
    test_full_win();
    test_error();
    test_restart_and_timeout();
    test_held_switch();
    test_play_on_timeout_cycle();
    test_reset_mid_game();
    test_timeout_disabled();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
